vga_timing_recovery: RTL and testbench
======================================

Name: vga_timing_recovery

Overview:
Receive-side counterpart of the VGA timing generator. Takes raw hsync/vsync from a pad or an upstream generator and detects their polarity. It measures horizontal total (pixels) and vertical total (lines), and locks when the timing is stable. Once locked it regenerates pixel coordinates x/y, an active flag and a frame-start strobe for downstream capture or overlay logic.

Parameters:
HW, 11, width of horizontal counter / x / h_total
VW, 10, width of vertical counter / y / v_total
H_SYNC_TO_ACTIVE, 144, pixels from hsync leading edge to first active pixel (sync+back porch)
H_RES, 640, active pixels per line
V_SYNC_TO_ACTIVE, 35, lines from first line after vsync leading edge to first active line
V_RES, 480, active lines per frame
LOCK_LINES, 4, consecutive equal h_total measurements required to leave HUNT

Ports:
clk  in  1  pixel clock
reset_n  in  1  reset, asynchronous, active-low
hsync_in  in  1  raw horizontal sync, any polarity, asynchronous to clk
vsync_in  in  1  raw vertical sync, any polarity
x  out  HW  active pixel column, 0..H_RES-1; 0 when not active
y  out  VW  active line, 0..V_RES-1; 0 when not active
active  out  1  1 while locked and inside active region
frame_start  out  1  one-cycle pulse with first active pixel (x=0,y=0)
locked  out  1  timing locked
h_total  out  HW  last measured line period in clk cycles
v_total  out  VW  last measured frame period in lines
h_pol  out  1  detected hsync polarity, 1 = active-high
v_pol  out  1  detected vsync polarity, 1 = active-high

Behaviour:
- Reset: all outputs 0; counters 0; state HUNT; h_pol=v_pol=0 (active-low default).
- Inputs pass a 2-flop synchroniser, then a third edge-detect flop. Total detection latency is 3 clk from pin to internal edge strobe. All coordinate outputs are registered and compensated, so x matches the pixel index as seen at the pin delayed by exactly 3 clk.
- Polarity: signed up/down accumulator per sync, width HW+VW+1 (+1 when raw high, -1 when low).
  - At each raw rising edge: pol <= (acc < 0), i.e. high is the minority. Then acc clears.
  - A change in either pol forces HUNT.
- Leading edge = transition into the active level per the current pol.
- Horizontal: hcnt resets to 0 on each hsync leading edge, otherwise increments.
  - On the leading edge, h_total <= hcnt+1 unless hcnt saturated.
  - hcnt saturates at 2^HW-1. Saturation = timeout: force HUNT, h_total <= 0.
- Vertical: vcnt increments on each hsync leading edge.
  - A vsync leading edge sets vpend. The next hsync leading edge loads vcnt <= 0 and clears vpend; on that same edge v_total <= vcnt+1.
  - If the vsync and hsync leading edges coincide, vcnt <= 0 in that cycle.
  - vcnt saturates at 2^VW-1 → HUNT.
- State machine (3 states):
  - HUNT: on each hsync leading edge, compare the new h_total with the previous one. Count matches; any mismatch resets the count. At LOCK_LINES matches → VERIFY.
  - VERIFY: wait for two vsync-terminated frames with equal v_total, v_total > V_SYNC_TO_ACTIVE+V_RES, and h_total > H_SYNC_TO_ACTIVE+H_RES. Then → LOCKED. Any h_total mismatch → HUNT.
  - LOCKED: locked=1. Any h_total or v_total mismatch, polarity change or saturation → HUNT in the same cycle. locked drops the next clk.
- Active region: hcnt in [H_SYNC_TO_ACTIVE, H_SYNC_TO_ACTIVE+H_RES) and vcnt in [V_SYNC_TO_ACTIVE, V_SYNC_TO_ACTIVE+V_RES) and LOCKED.
  - x = hcnt-H_SYNC_TO_ACTIVE; y = vcnt-V_SYNC_TO_ACTIVE.
  - Width: subtraction is done at HW+1/VW+1 bits and truncated only inside the region.
- frame_start = active && x==0 && y==0, one cycle, registered with x/y.
- reset_n asserted mid-frame: immediate return to reset values; relock requires the full HUNT/VERIFY sequence.

Decomposition:
- Package vga_rx_pkg: state enum {HUNT, VERIFY, LOCKED}; default timing constants for 640x480@60 (144, 640, 35, 480, totals 800/525).
- Sub-module sync_detect, instantiated twice (hsync, vsync), parameter ACC_W. It contains the synchroniser, polarity accumulator and leading-edge strobe. Outputs: sync_level, pol, lead_edge, pol_change.

Test Plan (small timing: hsync 4, bp 4, res 16, fp 4 → total 28; vsync 2, bp 2, res 8, fp 2 → total 14; H_SYNC_TO_ACTIVE=8, H_RES=16, V_SYNC_TO_ACTIVE=4, V_RES=8, LOCK_LINES=4):
1. Drive the reference generator with active-low syncs. Expected: h_pol=0, v_pol=0, h_total=28, v_total=14. locked rises during the third frame. Afterwards x counts 0..15 on 8 lines per frame, and frame_start pulses once per frame, 3 clk after pixel (0,0) at the pin.
2. Same timing with active-high syncs. Expected: h_pol=1, v_pol=1, identical x/y sequence.
3. While locked, stretch one line to 29 clk. Expected: locked=0 the clk after that hsync edge, active=0 and h_total=29. Relock occurs after normal timing resumes.
4. Hold hsync_in static for 2048 clk. Expected: timeout, state HUNT, h_total=0, locked=0.
5. Assert reset_n for 1 clk mid-active-line. Expected: all outputs 0 immediately, no frame_start until relock.
6. Make vsync and hsync leading edges coincide. Expected: v_total=14 unchanged and y sequence unchanged.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// Shared types and default 640x480@60 timing for the VGA receive path.
// Totals are kept for reference by capture/overlay blocks.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } rx_state_e;

  localparam int DEF_H_SYNC_TO_ACTIVE = 144;
  localparam int DEF_H_RES            = 640;
  localparam int DEF_V_SYNC_TO_ACTIVE = 35;
  localparam int DEF_V_RES            = 480;
  localparam int DEF_H_TOTAL          = 800;
  localparam int DEF_V_TOTAL          = 525;
  localparam int DEF_LOCK_LINES       = 4;

endpackage

// File: rtl/sync_detect.sv
// Synchroniser, polarity vote and leading-edge strobe for one raw sync.
// The vote window runs from one raw rising edge to the next.
module sync_detect #(
  parameter int ACC_W = 22
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic sync_level,
  output logic pol,
  output logic lead_edge,
  output logic pol_change
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic             s1_q, s2_q, s3_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             pol_q, pol_d;
  logic             rise, fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      acc_q <= '0;
      pol_q <= 1'b0;
    end else begin
      s1_q  <= sync_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      acc_q <= acc_d;
      pol_q <= pol_d;
    end
  end

  always_comb begin
    rise  = s2_q & ~s3_q;
    fall  = ~s2_q & s3_q;
    acc_d = acc_q;
    pol_d = pol_q;
    // Sign bit set means high was the minority level.
    if (rise) begin
      pol_d = acc_q[ACC_W-1];
      acc_d = '0;
    end else if (s2_q) begin
      if (acc_q != ACC_MAX) acc_d = acc_q + ACC_ONE;
    end else begin
      if (acc_q != ACC_MIN) acc_d = acc_q - ACC_ONE;
    end
  end

  assign sync_level = (s2_q == pol_q);
  assign pol        = pol_q;
  assign lead_edge  = pol_q ? rise : fall;
  assign pol_change = rise & (acc_q[ACC_W-1] != pol_q);

endmodule

// File: rtl/vga_timing_recovery.sv
// Recovers VGA timing from raw syncs and regenerates x/y/active.
// Outputs are computed from next-state counters to hide one register stage.
module vga_timing_recovery
  import vga_rx_pkg::*;
#(
  parameter int HW               = 11,
  parameter int VW               = 10,
  parameter int H_SYNC_TO_ACTIVE = DEF_H_SYNC_TO_ACTIVE,
  parameter int H_RES            = DEF_H_RES,
  parameter int V_SYNC_TO_ACTIVE = DEF_V_SYNC_TO_ACTIVE,
  parameter int V_RES            = DEF_V_RES,
  parameter int LOCK_LINES       = DEF_LOCK_LINES
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          active,
  output logic          frame_start,
  output logic          locked,
  output logic [HW-1:0] h_total,
  output logic [VW-1:0] v_total,
  output logic          h_pol,
  output logic          v_pol
);

  localparam int ACC_W = HW + VW + 1;
  localparam int MW    = $clog2(LOCK_LINES + 1);

  localparam logic [HW:0]   H_LO  = (HW+1)'(H_SYNC_TO_ACTIVE);
  localparam logic [HW:0]   H_HI  = (HW+1)'(H_SYNC_TO_ACTIVE + H_RES);
  localparam logic [VW:0]   V_LO  = (VW+1)'(V_SYNC_TO_ACTIVE);
  localparam logic [VW:0]   V_HI  = (VW+1)'(V_SYNC_TO_ACTIVE + V_RES);
  localparam logic [HW-1:0] H_MIN = HW'(H_SYNC_TO_ACTIVE + H_RES);
  localparam logic [VW-1:0] V_MIN = VW'(V_SYNC_TO_ACTIVE + V_RES);
  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;
  localparam logic [MW-1:0] M_TOP = MW'(LOCK_LINES - 1);

  logic h_lead, v_lead, h_pchg, v_pchg;
  logic h_level, v_level;
  logic unused_levels;

  sync_detect #(.ACC_W(ACC_W)) u_hsync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_in    (hsync_in),
    .sync_level (h_level),
    .pol        (h_pol),
    .lead_edge  (h_lead),
    .pol_change (h_pchg)
  );

  sync_detect #(.ACC_W(ACC_W)) u_vsync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_in    (vsync_in),
    .sync_level (v_level),
    .pol        (v_pol),
    .lead_edge  (v_lead),
    .pol_change (v_pchg)
  );

  assign unused_levels = h_level ^ v_level;

  rx_state_e       state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic            vpend_q, vpend_d;
  logic [HW-1:0]   h_total_q, h_total_d;
  logic [VW-1:0]   v_total_q, v_total_d;
  logic [MW-1:0]   hmatch_q, hmatch_d;
  logic            vseen_q, vseen_d;
  logic [HW-1:0]   x_q, x_d;
  logic [VW-1:0]   y_q, y_d;
  logic            active_q, active_d;
  logic            fs_q, fs_d;
  logic            locked_q, locked_d;

  logic            hsat, vsat, h_upd, v_upd;
  logic            h_bad, v_bad, frame_ok, force_hunt;
  logic [HW:0]     hx;
  logic [VW:0]     vy;
  logic            in_h, in_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      vpend_q   <= 1'b0;
      h_total_q <= '0;
      v_total_q <= '0;
      hmatch_q  <= '0;
      vseen_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      active_q  <= 1'b0;
      fs_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      vpend_q   <= vpend_d;
      h_total_q <= h_total_d;
      v_total_q <= v_total_d;
      hmatch_q  <= hmatch_d;
      vseen_q   <= vseen_d;
      x_q       <= x_d;
      y_q       <= y_d;
      active_q  <= active_d;
      fs_q      <= fs_d;
      locked_q  <= locked_d;
    end
  end

  always_comb begin
    hsat      = (hcnt_q == H_MAX);
    vsat      = (vcnt_q == V_MAX);
    hcnt_d    = hcnt_q;
    h_total_d = h_total_q;
    h_upd     = 1'b0;
    if (h_lead) hcnt_d = '0;
    else if (!hsat) hcnt_d = hcnt_q + HW'(1);
    if (hsat) begin
      h_total_d = '0;
    end else if (h_lead) begin
      h_total_d = hcnt_q + HW'(1);
      h_upd     = 1'b1;
    end

    // A pending or coincident vsync edge closes the frame on this line edge.
    vcnt_d    = vcnt_q;
    vpend_d   = vpend_q;
    v_total_d = v_total_q;
    v_upd     = 1'b0;
    if (h_lead) begin
      if (vpend_q || v_lead) begin
        vcnt_d    = '0;
        vpend_d   = 1'b0;
        v_total_d = vcnt_q + VW'(1);
        v_upd     = 1'b1;
      end else if (!vsat) begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end else if (v_lead) begin
      vpend_d = 1'b1;
    end

    h_bad      = h_upd && (h_total_d != h_total_q);
    v_bad      = v_upd && (v_total_d != v_total_q);
    frame_ok   = (v_total_d > V_MIN) && (h_total_q > H_MIN);
    force_hunt = hsat || vsat || h_pchg || v_pchg;

    state_d  = state_q;
    hmatch_d = hmatch_q;
    vseen_d  = vseen_q;
    if (force_hunt) begin
      state_d  = HUNT;
      hmatch_d = '0;
      vseen_d  = 1'b0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (h_upd) begin
            if (h_bad) begin
              hmatch_d = '0;
            end else if (hmatch_q == M_TOP) begin
              state_d  = VERIFY;
              hmatch_d = '0;
              vseen_d  = 1'b0;
            end else begin
              hmatch_d = hmatch_q + MW'(1);
            end
          end
        end
        VERIFY: begin
          if (h_bad) begin
            state_d  = HUNT;
            hmatch_d = '0;
          end else if (v_upd) begin
            if (vseen_q && !v_bad && frame_ok) state_d = LOCKED;
            vseen_d = 1'b1;
          end
        end
        LOCKED: begin
          if (h_bad || v_bad) begin
            state_d  = HUNT;
            hmatch_d = '0;
            vseen_d  = 1'b0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    hx       = {1'b0, hcnt_d} - H_LO;
    vy       = {1'b0, vcnt_d} - V_LO;
    in_h     = ({1'b0, hcnt_d} >= H_LO) && ({1'b0, hcnt_d} < H_HI);
    in_v     = ({1'b0, vcnt_d} >= V_LO) && ({1'b0, vcnt_d} < V_HI);
    locked_d = (state_d == LOCKED);
    active_d = in_h && in_v && locked_d;
    x_d      = active_d ? hx[HW-1:0] : '0;
    y_d      = active_d ? vy[VW-1:0] : '0;
    fs_d     = active_d && (hx == '0) && (vy == '0);
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Bench for vga_timing_recovery: small 28x14 timing, table scenarios
// plus stretch, timeout and mid-line reset sequences.
module tb_vga_timing_recovery;

  localparam int HW    = 11;
  localparam int VW    = 10;
  localparam int HS    = 4;
  localparam int HBP   = 4;
  localparam int HRES  = 16;
  localparam int HFP   = 4;
  localparam int HT    = HS + HBP + HRES + HFP;
  localparam int VS    = 2;
  localparam int VBP   = 2;
  localparam int VRES  = 8;
  localparam int VFP   = 2;
  localparam int VT    = VS + VBP + VRES + VFP;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hsync_in;
  logic          vsync_in;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          active;
  logic          frame_start;
  logic          locked;
  logic [HW-1:0] h_total;
  logic [VW-1:0] v_total;
  logic          h_pol;
  logic          v_pol;

  vga_timing_recovery #(
    .HW               (HW),
    .VW               (VW),
    .H_SYNC_TO_ACTIVE (HS + HBP),
    .H_RES            (HRES),
    .V_SYNC_TO_ACTIVE (VS + VBP),
    .V_RES            (VRES),
    .LOCK_LINES       (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .x           (x),
    .y           (y),
    .active      (active),
    .frame_start (frame_start),
    .locked      (locked),
    .h_total     (h_total),
    .v_total     (v_total),
    .h_pol       (h_pol),
    .v_pol       (v_pol)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int line;
    bit run;
  } pos_t;

  typedef struct {
    bit hp;
    bit vp;
    bit coinc;
    bit exp_hpol;
    bit exp_vpol;
    int exp_ht;
    int exp_vt;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   nprint = 0;
  int   gpix, gline, voff;
  bit   hp, vp, gen_run, stretch, chk_en;
  pos_t hist[$];
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // vsync is the frame's line-0 window, shifted voff pixels early.
  function automatic bit vs_act(input int p, input int l);
    int sl;
    sl = l;
    if (p + voff >= HT) sl = (l + 1) % VT;
    return sl < VS;
  endfunction

  task automatic check_stream(input pos_t e);
    bit a, fs;
    int ex, ey;
    a  = e.pix >= HS + HBP && e.pix < HS + HBP + HRES &&
         e.line >= VS + VBP && e.line < VS + VBP + VRES;
    ex = a ? e.pix - (HS + HBP) : 0;
    ey = a ? e.line - (VS + VBP) : 0;
    fs = a && ex == 0 && ey == 0;
    n_chk++;
    if (active !== a || x !== HW'(ex) || y !== VW'(ey) ||
        frame_start !== fs || locked !== 1'b1) begin
      n_fail++;
      if (nprint < 20)
        $display("FAIL stream pix=%0d line=%0d: got act=%b x=%0d y=%0d fs=%b lk=%b, want act=%b x=%0d y=%0d fs=%b lk=1",
                 e.pix, e.line, active, x, y, frame_start, locked,
                 a, ex, ey, fs);
      nprint++;
    end
  endtask

  task automatic tick();
    pos_t e;
    @(posedge clk);
    #1;
    e.pix  = gpix;
    e.line = gline;
    e.run  = gen_run;
    if (gen_run) begin
      hsync_in = (gpix < HS) ? hp : ~hp;
      vsync_in = vs_act(gpix, gline) ? vp : ~vp;
      if (stretch && gpix == HT - 1) begin
        stretch = 1'b0;
      end else if (gpix == HT - 1) begin
        gpix  = 0;
        gline = (gline + 1) % VT;
      end else begin
        gpix++;
      end
    end else begin
      hsync_in = ~hp;
      vsync_in = ~vp;
    end
    hist.push_back(e);
    if (hist.size() > 4) void'(hist.pop_front());
    @(negedge clk);
    if (chk_en && hist.size() == 4) check_stream(hist[0]);
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) tick();
  endtask

  task automatic advance_to(input int l, input int p);
    int n;
    n = 0;
    while (!(gline == l && gpix == p) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("advance_bound", 32'(gline == l && gpix == p), 1);
  endtask

  task automatic check_locked(input string tag, input int ht, input int vt);
    chk({tag, "_locked"}, locked, 1);
    chk({tag, "_h_total"}, h_total, ht);
    chk({tag, "_v_total"}, v_total, vt);
  endtask

  task automatic run_scenario(input vec_t v, input int idx);
    string tag;
    tag     = $sformatf("s%0d", idx);
    chk_en  = 1'b0;
    gen_run = 1'b0;
    stretch = 1'b0;
    hp      = v.hp;
    vp      = v.vp;
    voff    = v.coinc ? 0 : int'($urandom_range(1, 6));
    gpix    = 0;
    gline   = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk({tag, "_rst_x"}, x, 0);
    chk({tag, "_rst_y"}, y, 0);
    chk({tag, "_rst_flags"}, {active, frame_start, locked, h_pol, v_pol}, 0);
    chk({tag, "_rst_totals"}, {h_total, v_total}, 0);
    reset_n = 1'b1;
    repeat ($urandom_range(0, 40)) tick();
    gen_run = 1'b1;
    run_frames(8);
    chk({tag, "_h_pol"}, h_pol, v.exp_hpol);
    chk({tag, "_v_pol"}, v_pol, v.exp_vpol);
    check_locked(tag, v.exp_ht, v.exp_vt);
    chk_en = 1'b1;
    run_frames(2);
    chk_en = 1'b0;
  endtask

  initial begin
    int fs_cnt;
    reset_n  = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    chk_en   = 1'b0;
    gen_run  = 1'b0;
    stretch  = 1'b0;
    voff     = 0;
    gpix     = 0;
    gline    = 0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HT, VT};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, HT, VT};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, HT, VT};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, HT, VT};

    for (int i = 0; i < 4; i++) run_scenario(tbl[i], i);

    // One 29-clk line while locked.
    advance_to(6, HT - 1);
    stretch = 1'b1;
    advance_to(7, 0);
    tick();
    tick();
    tick();
    chk("stretch_locked_before", locked, 1);
    tick();
    chk("stretch_locked_after", locked, 0);
    chk("stretch_h_total", h_total, HT + 1);
    chk("stretch_active", active, 0);
    run_frames(8);
    check_locked("stretch_relock", HT, VT);
    chk_en = 1'b1;
    run_frames(1);
    chk_en = 1'b0;

    // Static hsync long enough to saturate the line counter.
    gen_run = 1'b0;
    repeat (2060) tick();
    chk("timeout_h_total", h_total, 0);
    chk("timeout_locked", locked, 0);
    chk("timeout_active", active, 0);
    gen_run = 1'b1;
    run_frames(8);
    check_locked("timeout_relock", HT, VT);
    chk_en = 1'b1;
    run_frames(1);
    chk_en = 1'b0;

    // Reset pulse in the middle of an active line.
    advance_to(6, 14);
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_x", x, 0);
    chk("midrst_y", y, 0);
    chk("midrst_flags", {active, frame_start, locked, h_pol, v_pol}, 0);
    chk("midrst_totals", {h_total, v_total}, 0);
    tick();
    reset_n = 1'b1;
    fs_cnt = 0;
    repeat (FRAME) begin
      tick();
      if (frame_start === 1'b1) fs_cnt++;
    end
    chk("midrst_no_frame_start", fs_cnt, 0);
    run_frames(8);
    check_locked("midrst_relock", HT, VT);
    chk_en = 1'b1;
    run_frames(1);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
